// File: rtl/vga_timing_gen.sv
// VGA timing generator with per-axis porch/sync parameters, a pixel-enable qualifier,
// and registered sync, position, data-enable and line/frame start strobes.
module vga_timing_gen #(
  parameter int H_ACTIVE    = 640,
  parameter int H_FP        = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BP        = 48,
  parameter int V_ACTIVE    = 480,
  parameter int V_FP        = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BP        = 33,
  parameter bit HSYNC_POL   = 1'b0,
  parameter bit VSYNC_POL   = 1'b0,
  parameter int COUNT_WIDTH = 10
) (
  input  logic                   i_Clk,
  input  logic                   i_Rst_L,
  input  logic                   i_Enable,
  output logic                   o_HSync,
  output logic                   o_VSync,
  output logic                   o_Active,
  output logic [COUNT_WIDTH-1:0] o_Col_Count,
  output logic [COUNT_WIDTH-1:0] o_Row_Count,
  output logic                   o_Line_Start,
  output logic                   o_Frame_Start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  if ((H_TOTAL > (1 << COUNT_WIDTH)) || (V_TOTAL > (1 << COUNT_WIDTH))) begin : g_width_check
    $error("vga_timing_gen: COUNT_WIDTH too small for H_TOTAL/V_TOTAL");
  end
  if ((H_ACTIVE < 1) || (H_SYNC < 1) || (V_ACTIVE < 1) || (V_SYNC < 1)) begin : g_param_check
    $error("vga_timing_gen: active and sync lengths must be at least 1");
  end
  if ((H_FP < 0) || (H_BP < 0) || (V_FP < 0) || (V_BP < 0)) begin : g_porch_check
    $error("vga_timing_gen: porch lengths must not be negative");
  end

  localparam logic [COUNT_WIDTH-1:0] H_LAST   = COUNT_WIDTH'(H_TOTAL - 1);
  localparam logic [COUNT_WIDTH-1:0] V_LAST   = COUNT_WIDTH'(V_TOTAL - 1);
  localparam logic [COUNT_WIDTH-1:0] H_ACT    = COUNT_WIDTH'(H_ACTIVE);
  localparam logic [COUNT_WIDTH-1:0] V_ACT    = COUNT_WIDTH'(V_ACTIVE);
  localparam logic [COUNT_WIDTH-1:0] HS_FIRST = COUNT_WIDTH'(H_ACTIVE + H_FP);
  localparam logic [COUNT_WIDTH-1:0] HS_LAST  = COUNT_WIDTH'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [COUNT_WIDTH-1:0] VS_FIRST = COUNT_WIDTH'(V_ACTIVE + V_FP);
  localparam logic [COUNT_WIDTH-1:0] VS_LAST  = COUNT_WIDTH'(V_ACTIVE + V_FP + V_SYNC - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t                 state, state_next;
  logic [COUNT_WIDTH-1:0] col_next, row_next;
  logic                   hsync_next, vsync_next, active_next;
  logic                   line_next, frame_next;

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state         <= IDLE;
      o_Col_Count   <= '0;
      o_Row_Count   <= '0;
      o_Active      <= 1'b0;
      o_HSync       <= ~HSYNC_POL;
      o_VSync       <= ~VSYNC_POL;
      o_Line_Start  <= 1'b0;
      o_Frame_Start <= 1'b0;
    end else begin
      state         <= state_next;
      o_Col_Count   <= col_next;
      o_Row_Count   <= row_next;
      o_Active      <= active_next;
      o_HSync       <= hsync_next;
      o_VSync       <= vsync_next;
      o_Line_Start  <= line_next;
      o_Frame_Start <= frame_next;
    end
  end

  // Outputs are decoded from the position about to be presented, so every registered
  // output describes the same pixel as the counts beside it.
  always_comb begin
    state_next  = state;
    col_next    = o_Col_Count;
    row_next    = o_Row_Count;
    active_next = o_Active;
    hsync_next  = o_HSync;
    vsync_next  = o_VSync;
    line_next   = 1'b0;
    frame_next  = 1'b0;
    if (i_Enable) begin
      case (state)
        IDLE: begin
          state_next = RUN;
          col_next   = '0;
          row_next   = '0;
        end
        RUN: begin
          if (o_Col_Count == H_LAST) begin
            col_next = '0;
            row_next = (o_Row_Count == V_LAST) ? '0 : o_Row_Count + COUNT_WIDTH'(1);
          end else begin
            col_next = o_Col_Count + COUNT_WIDTH'(1);
          end
        end
        default: state_next = IDLE;
      endcase
      active_next = (col_next < H_ACT) && (row_next < V_ACT);
      hsync_next  = ((col_next >= HS_FIRST) && (col_next <= HS_LAST)) ? HSYNC_POL : ~HSYNC_POL;
      vsync_next  = ((row_next >= VS_FIRST) && (row_next <= VS_LAST)) ? VSYNC_POL : ~VSYNC_POL;
      line_next   = (col_next == '0);
      frame_next  = (col_next == '0) && (row_next == '0);
    end
  end

endmodule
